// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and Q4.8 constants for the 64-point FFT datapath
// (twiddle ROM, radix-2 butterfly, stage controller).
package fft_pkg;
   localparam int FFT_DW      = 16;
   localparam int FFT_TW      = 12;
   localparam int FFT_TW_FRAC = 8;
   localparam int Q48_ONE     = 256;

   // width of one complex sample (re and im packed side by side)
   function automatic int cplx_w(input int dw);
      return 2 * dw;
   endfunction

   // butterfly outputs carry two guard bits so a +/- b*W never wraps
   function automatic int bfly_ow(input int dw);
      return dw + 2;
   endfunction

   function automatic int prod_w(input int dw, input int tw);
      return dw + tw;
   endfunction
endpackage

// File: rtl/fft_cmul_q48.sv
// fft_cmul_q48: two-stage complex multiply b*W with a Q4.8 twiddle, a carried alongside.
// FFT_BFLY_ROUND_EN: round-half-up before the shift; otherwise floor (truncating) shift.
module fft_cmul_q48
   import fft_pkg::*;
#(
   parameter int DW      = FFT_DW,
   parameter int TW      = FFT_TW,
   parameter int TW_FRAC = FFT_TW_FRAC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en1,
   input  logic                 en2,
   input  logic signed [DW-1:0] a_re,
   input  logic signed [DW-1:0] a_im,
   input  logic signed [DW-1:0] b_re,
   input  logic signed [DW-1:0] b_im,
   input  logic signed [TW-1:0] tw_cos,
   input  logic signed [TW-1:0] tw_sin,
   output logic signed [DW-1:0] a2_re,
   output logic signed [DW-1:0] a2_im,
   output logic signed [DW+1:0] bw_re,
   output logic signed [DW+1:0] bw_im
);
   localparam int PW = prod_w(DW, TW);
   localparam int SW = PW + 1;
   localparam int OW = bfly_ow(DW);
`ifdef FFT_BFLY_ROUND_EN
   localparam logic signed [SW-1:0] RND = SW'(1) << (TW_FRAC - 1);
`else
   localparam logic signed [SW-1:0] RND = '0;
`endif

   logic signed [PW-1:0] rc_q, rc_d, is_q, is_d, rs_q, rs_d, ic_q, ic_d;
   logic signed [DW-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
   logic signed [DW-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
   logic signed [SW-1:0] sum_re, sum_im;
   logic signed [OW-1:0] bw_re_q, bw_re_d, bw_im_q, bw_im_d;

   always_comb begin
      rc_d    = en1 ? PW'(b_re) * PW'(tw_cos) : rc_q;
      is_d    = en1 ? PW'(b_im) * PW'(tw_sin) : is_q;
      rs_d    = en1 ? PW'(b_re) * PW'(tw_sin) : rs_q;
      ic_d    = en1 ? PW'(b_im) * PW'(tw_cos) : ic_q;
      a1_re_d = en1 ? a_re : a1_re_q;
      a1_im_d = en1 ? a_im : a1_im_q;
      // one extra bit so the sum of two full products cannot wrap before the shift
      sum_re  = SW'(rc_q) - SW'(is_q) + RND;
      sum_im  = SW'(rs_q) + SW'(ic_q) + RND;
      bw_re_d = en2 ? OW'(sum_re >>> TW_FRAC) : bw_re_q;
      bw_im_d = en2 ? OW'(sum_im >>> TW_FRAC) : bw_im_q;
      a2_re_d = en2 ? a1_re_q : a2_re_q;
      a2_im_d = en2 ? a1_im_q : a2_im_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_q    <= '0;
         is_q    <= '0;
         rs_q    <= '0;
         ic_q    <= '0;
         a1_re_q <= '0;
         a1_im_q <= '0;
         bw_re_q <= '0;
         bw_im_q <= '0;
         a2_re_q <= '0;
         a2_im_q <= '0;
      end else begin
         rc_q    <= rc_d;
         is_q    <= is_d;
         rs_q    <= rs_d;
         ic_q    <= ic_d;
         a1_re_q <= a1_re_d;
         a1_im_q <= a1_im_d;
         bw_re_q <= bw_re_d;
         bw_im_q <= bw_im_d;
         a2_re_q <= a2_re_d;
         a2_im_q <= a2_im_d;
      end
   end

   assign a2_re = a2_re_q;
   assign a2_im = a2_im_q;
   assign bw_re = bw_re_q;
   assign bw_im = bw_im_q;
endmodule

// File: rtl/fft_bfly_r2.sv
// fft_bfly_r2: 3-stage elastic radix-2 DIT butterfly, y0 = a + b*W, y1 = a - b*W.
// Rounding of b*W is selected by FFT_BFLY_ROUND_EN inside fft_cmul_q48.
module fft_bfly_r2
   import fft_pkg::*;
#(
   parameter int DW      = FFT_DW,
   parameter int TW      = FFT_TW,
   parameter int TW_FRAC = FFT_TW_FRAC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] a_re,
   input  logic signed [DW-1:0] a_im,
   input  logic signed [DW-1:0] b_re,
   input  logic signed [DW-1:0] b_im,
   input  logic signed [TW-1:0] tw_cos,
   input  logic signed [TW-1:0] tw_sin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW+1:0] y0_re,
   output logic signed [DW+1:0] y0_im,
   output logic signed [DW+1:0] y1_re,
   output logic signed [DW+1:0] y1_im
);
   localparam int OW = bfly_ow(DW);

   logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic                 en1, en2, en3, ld1, ld2, ld3;
   logic signed [DW-1:0] a2_re, a2_im;
   logic signed [OW-1:0] bw_re, bw_im;
   logic signed [OW-1:0] y0_re_q, y0_re_d, y0_im_q, y0_im_d;
   logic signed [OW-1:0] y1_re_q, y1_re_d, y1_im_q, y1_im_d;

   // a stage may advance when it is empty or the stage after it advances
   always_comb begin
      en3     = ~v3_q | out_ready;
      en2     = ~v2_q | en3;
      en1     = ~v1_q | en2;
      ld1     = en1 & in_valid;
      ld2     = en2 & v1_q;
      ld3     = en3 & v2_q;
      v1_d    = en1 ? in_valid : v1_q;
      v2_d    = en2 ? v1_q : v2_q;
      v3_d    = en3 ? v2_q : v3_q;
      y0_re_d = ld3 ? OW'(a2_re) + bw_re : y0_re_q;
      y0_im_d = ld3 ? OW'(a2_im) + bw_im : y0_im_q;
      y1_re_d = ld3 ? OW'(a2_re) - bw_re : y1_re_q;
      y1_im_d = ld3 ? OW'(a2_im) - bw_im : y1_im_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         y0_re_q <= '0;
         y0_im_q <= '0;
         y1_re_q <= '0;
         y1_im_q <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         y0_re_q <= y0_re_d;
         y0_im_q <= y0_im_d;
         y1_re_q <= y1_re_d;
         y1_im_q <= y1_im_d;
      end
   end

   fft_cmul_q48 #(
      .DW      (DW),
      .TW      (TW),
      .TW_FRAC (TW_FRAC)
   ) u_cmul (
      .clk    (clk),
      .rst_n  (rst_n),
      .en1    (ld1),
      .en2    (ld2),
      .a_re   (a_re),
      .a_im   (a_im),
      .b_re   (b_re),
      .b_im   (b_im),
      .tw_cos (tw_cos),
      .tw_sin (tw_sin),
      .a2_re  (a2_re),
      .a2_im  (a2_im),
      .bw_re  (bw_re),
      .bw_im  (bw_im)
   );

   assign in_ready  = en1;
   assign out_valid = v3_q;
   assign y0_re     = y0_re_q;
   assign y0_im     = y0_im_q;
   assign y1_re     = y1_re_q;
   assign y1_im     = y1_im_q;
endmodule

// File: tb/tb_fft_bfly_r2.sv
// tb_fft_bfly_r2: scoreboard bench for fft_bfly_r2 against an integer complex-arithmetic model.
`timescale 1ns/1ps
module tb_fft_bfly_r2;
   import fft_pkg::*;
   localparam int DW = FFT_DW;
   localparam int TW = FFT_TW;
   localparam int OW = DW + 2;

   typedef struct {int y0r; int y0i; int y1r; int y1i;} exp_t;

   logic                 clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic                 in_ready, out_valid;
   logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic signed [TW-1:0] tw_cos = '0, tw_sin = '0;
   logic signed [OW-1:0] y0_re, y0_im, y1_re, y1_im;

   exp_t sbq[$];
   exp_t held;
   bit   held_v = 0, stall_seen = 0;
   int   n_vec = 0, n_err = 0, rdy_mode = 0;

   always #5 clk = ~clk;

   fft_bfly_r2 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .tw_cos(tw_cos), .tw_sin(tw_sin),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im)
   );

   task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // floor division by the Q4.8 unit
   function automatic int fdiv(input longint n);
      longint q;
      q = n / Q48_ONE;
      if ((n % Q48_ONE) != 0 && n < 0) q = q - 1;
      return int'(q);
   endfunction

   function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                  input int c, input int s);
      longint r;
      int     wr, wi;
      exp_t   e;
`ifdef FFT_BFLY_ROUND_EN
      r = Q48_ONE / 2;
`else
      r = 0;
`endif
      wr = fdiv(longint'(br) * c - longint'(bi) * s + r);
      wi = fdiv(longint'(br) * s + longint'(bi) * c + r);
      e.y0r = ar + wr;
      e.y0i = ai + wi;
      e.y1r = ar - wr;
      e.y1i = ai - wi;
      return e;
   endfunction

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input int c, input int s);
      int w = 0;
      a_re = ar[DW-1:0];
      a_im = ai[DW-1:0];
      b_re = br[DW-1:0];
      b_im = bi[DW-1:0];
      tw_cos = c[TW-1:0];
      tw_sin = s[TW-1:0];
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", w);
            break;
         end
      end
      if (in_ready) sbq.push_back(model(ar, ai, br, bi, c, s));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sbq.size() != 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain_pending", sbq.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // monitor: inputs settle by posedge+1, so the negedge sees the upcoming handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) held_v = 0;
      else begin
         if (held_v) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_y0re", y0_re, held.y0r);
            chk("stall_y0im", y0_im, held.y0i);
            chk("stall_y1re", y1_re, held.y1r);
            chk("stall_y1im", y1_im, held.y1i);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out: got y0=(%0d,%0d) expected no beat", y0_re, y0_im);
            end else begin
               e = sbq.pop_front();
               chk("y0_re", y0_re, e.y0r);
               chk("y0_im", y0_im, e.y0i);
               chk("y1_re", y1_re, e.y1r);
               chk("y1_im", y1_im, e.y1i);
            end
         end
         held_v = out_valid && !out_ready;
         held.y0r = y0_re;
         held.y0i = y0_im;
         held.y1r = y1_re;
         held.y1i = y1_im;
         if (!in_ready) stall_seen = 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y0_re", y0_re, 0);
      chk("rst_y1_im", y1_im, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // W0 with latency check
      send(100, -50, 30, 20, Q48_ONE, 0);
      chk("lat_c1", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_c2", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_c3", out_valid, 1);
      chk("w0_y0_re", y0_re, 130);
      chk("w0_y0_im", y0_im, -30);
      chk("w0_y1_re", y1_re, 70);
      chk("w0_y1_im", y1_im, -70);
      // W16, W8 and range extremes back to back
      send(0, 0, 30, 20, 0, -256);
      send(0, 0, 1, 0, 181, -181);
      send(32767, 32767, 32767, 32767, 256, 0);
      send(-32768, -32768, -32768, -32768, -256, 0);
      send(-32768, 32767, 32767, -32768, 181, -181);
      drain();
      // backpressure: 8 back-to-back beats with a 4-cycle out_ready drop
      stall_seen = 0;
      fork
         for (int i = 0; i < 8; i++)
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 512)) - 256);
         begin
            repeat (3) @(posedge clk);
            #2 rdy_mode = 2;
            repeat (4) @(posedge clk);
            #2 rdy_mode = 0;
         end
      join
      drain();
      chk("bp_in_ready_fell", stall_seen, 1);
      // random traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end else
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 512)) - 256);
      end
      rdy_mode = 0;
      drain();
      // reset with three beats in flight
      rdy_mode = 2;
      @(posedge clk);
      #2;
      send(1000, -2000, 300, 400, 256, 0);
      send(-5, 7, 123, -456, 181, -181);
      send(77, 88, -99, 11, 0, -256);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1'b1;
      #1;
      chk("full_free_in_ready", in_ready, 1);
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_y0_re", y0_re, 0);
      chk("async_rst_y0_im", y0_im, 0);
      chk("async_rst_y1_re", y1_re, 0);
      chk("async_rst_y1_im", y1_im, 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("no_stale_beat", out_valid, 0);
      end
      send(-300, 250, -1234, 4321, -181, -181);
      @(posedge clk);
      #1;
      chk("post_rst_lat_c2", out_valid, 0);
      @(posedge clk);
      #1;
      chk("post_rst_lat_c3", out_valid, 1);
      drain();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
